// File: rtl/pc_gen.sv
// Program-counter generator for the single-issue core: sequential/branch/jump/return
// target selection with trap redirect, stall hold, misaligned-target detection and a return-address stack.
module pc_gen #(
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = 'h10074,
    parameter int                    IALIGN     = 4,
    parameter int                    RAS_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            ctrl_sel_i,
    input  logic [ADDR_WIDTH-1:0] offset_i,
    input  logic                  branch_tkn_i,
    input  logic [ADDR_WIDTH-1:0] tgt_addr_i,
    input  logic                  push_i,
    input  logic                  stall_i,
    input  logic                  trap_i,
    input  logic [ADDR_WIDTH-1:0] trap_vec_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic [ADDR_WIDTH-1:0] pc_plus4_o,
    output logic                  pc_valid_o,
    output logic                  misalign_o,
    output logic                  ras_empty_o,
    output logic                  ras_full_o
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'b00,
        SEL_JUMP   = 2'b01,
        SEL_BRANCH = 2'b10,
        SEL_RETURN = 2'b11
    } ctrl_sel_e;

    logic [ADDR_WIDTH-1:0] pc_q;
    logic                  valid_q;
    logic                  misalign_q;
    logic [PTR_W-1:0]      ptr_q;
    logic [OCC_W-1:0]      occ_q;
    logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];

    ctrl_sel_e               sel;
    logic signed [ADDR_WIDTH-1:0] offset_s;
    logic signed [ADDR_WIDTH-1:0] branch_tgt;
    logic [ADDR_WIDTH-1:0]   jump_tgt;
    logic [ADDR_WIDTH-1:0]   ras_top;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic                    next_misaligned;
    logic                    ras_empty;
    logic                    ras_full;
    logic                    do_pop;
    logic                    do_push;
    logic                    advance;
    logic                    ras_wr_en;
    logic [PTR_W-1:0]        ras_wr_idx;
    logic [PTR_W-1:0]        ptr_inc;
    logic [PTR_W-1:0]        ptr_dec;

    assign pc_o        = pc_q;
    assign pc_plus4_o  = pc_q + ADDR_WIDTH'(4);
    assign pc_valid_o  = valid_q;
    assign misalign_o  = misalign_q;
    assign ras_empty_o = ras_empty;
    assign ras_full_o  = ras_full;

    always_comb begin
        sel        = ctrl_sel_e'(ctrl_sel_i);
        offset_s   = $signed(offset_i);
        branch_tgt = $signed(pc_q) + offset_s;
        jump_tgt   = tgt_addr_i & ~ADDR_WIDTH'(1);
        ras_top    = ras_mem[ptr_q];
        ras_empty  = (occ_q == '0);
        ras_full   = (occ_q == OCC_W'(RAS_DEPTH));
        ptr_inc    = ptr_q + PTR_W'(1);
        ptr_dec    = ptr_q - PTR_W'(1);

        next_pc = pc_plus4_o;
        unique case (sel)
            SEL_NONE:   next_pc = pc_plus4_o;
            SEL_JUMP:   next_pc = jump_tgt;
            SEL_BRANCH: next_pc = branch_tkn_i ? ADDR_WIDTH'(branch_tgt) : pc_plus4_o;
            SEL_RETURN: next_pc = ras_empty ? jump_tgt : ras_top;
            default:    next_pc = pc_plus4_o;
        endcase

        // Jump/return targets already have bit 0 cleared, so with IALIGN=2 only a branch can trip this.
        next_misaligned = (IALIGN == 4) ? next_pc[1] : next_pc[0];

        advance = !rst && !trap_i && !stall_i && !next_misaligned;
        do_pop  = (sel == SEL_RETURN) && !ras_empty;
        do_push = push_i && ((sel == SEL_JUMP) || (sel == SEL_RETURN));

        // Pop+push replaces the top in place; a plain push lands one slot above it.
        ras_wr_en  = advance && do_push;
        ras_wr_idx = do_pop ? ptr_q : ptr_inc;
    end

    // ---- state update: control registers carry the reset ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_ADDR;
            valid_q    <= 1'b0;
            misalign_q <= 1'b0;
            ptr_q      <= '0;
            occ_q      <= '0;
        end else begin
            valid_q <= 1'b1;
            if (trap_i) begin
                pc_q       <= trap_vec_i;
                misalign_q <= 1'b0;
            end else if (stall_i) begin
                misalign_q <= 1'b0;
            end else if (next_misaligned) begin
                misalign_q <= 1'b1;
            end else begin
                pc_q       <= next_pc;
                misalign_q <= 1'b0;
                if (do_push && !do_pop) begin
                    ptr_q <= ptr_inc;
                    if (!ras_full) begin
                        occ_q <= occ_q + OCC_W'(1);
                    end
                end else if (do_pop && !do_push) begin
                    ptr_q <= ptr_dec;
                    occ_q <= occ_q - OCC_W'(1);
                end
            end
        end
    end

    // ---- RAS storage: data only, validity is tracked by occ_q ----
    always_ff @(posedge clk) begin
        if (ras_wr_en) begin
            ras_mem[ras_wr_idx] <= pc_plus4_o;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic, checked cycle by cycle
// against a queue-based reference model of the PC and return-address stack.
module tb_pc_gen;

    localparam int          AW    = 32;
    localparam logic [31:0] RADDR = 32'h10074;
    localparam int          DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    ctrl_sel;
    logic [AW-1:0] offset;
    logic          branch_tkn;
    logic [AW-1:0] tgt_addr;
    logic          push;
    logic          stall;
    logic          trap;
    logic [AW-1:0] trap_vec;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus4;
    logic          pc_valid;
    logic          misalign;
    logic          ras_empty;
    logic          ras_full;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_mis;
    logic [31:0] m_ras[$];

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_WIDTH(AW),
        .RESET_ADDR(RADDR),
        .IALIGN    (4),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ctrl_sel_i  (ctrl_sel),
        .offset_i    (offset),
        .branch_tkn_i(branch_tkn),
        .tgt_addr_i  (tgt_addr),
        .push_i      (push),
        .stall_i     (stall),
        .trap_i      (trap),
        .trap_vec_i  (trap_vec),
        .pc_o        (pc),
        .pc_plus4_o  (pc_plus4),
        .pc_valid_o  (pc_valid),
        .misalign_o  (misalign),
        .ras_empty_o (ras_empty),
        .ras_full_o  (ras_full)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: the RAS is a list of link addresses, newest at the back, capped at DEPTH.
    task automatic model_edge();
        logic [31:0] nxt;
        logic [31:0] link;
        logic        bad;
        if (rst) begin
            m_pc = RADDR; m_valid = 1'b0; m_mis = 1'b0; m_ras.delete();
        end else begin
            m_valid = 1'b1;
            if (trap) begin
                m_pc = trap_vec; m_mis = 1'b0;
            end else if (stall) begin
                m_mis = 1'b0;
            end else begin
                case (ctrl_sel)
                    2'b00:   nxt = m_pc + 32'd4;
                    2'b01:   nxt = {tgt_addr[31:1], 1'b0};
                    2'b10:   nxt = branch_tkn ? m_pc + offset : m_pc + 32'd4;
                    default: nxt = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : {tgt_addr[31:1], 1'b0};
                endcase
                bad = nxt[1];
                if (bad) begin
                    m_mis = 1'b1;
                end else begin
                    link  = m_pc + 32'd4;
                    m_pc  = nxt;
                    m_mis = 1'b0;
                    if (ctrl_sel == 2'b11 && m_ras.size() > 0) void'(m_ras.pop_back());
                    if (push && (ctrl_sel == 2'b01 || ctrl_sel == 2'b11)) begin
                        m_ras.push_back(link);
                        if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                    end
                end
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check("pc", pc, m_pc);
        check("pc_plus4", pc_plus4, m_pc + 32'd4);
        check("pc_valid", {31'b0, pc_valid}, {31'b0, m_valid});
        check("misalign", {31'b0, misalign}, {31'b0, m_mis});
        check("ras_empty", {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
        check("ras_full", {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
    endtask

    task automatic idle();
        rst = 1'b0; ctrl_sel = 2'b00; offset = '0; branch_tkn = 1'b0; tgt_addr = '0;
        push = 1'b0; stall = 1'b0; trap = 1'b0; trap_vec = '0;
    endtask

    task automatic do_trap(input logic [31:0] vec);
        idle(); trap = 1'b1; trap_vec = vec; cycle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        cycle();
        check("rst_pc", pc, 32'h10074);
        check("rst_valid", {31'b0, pc_valid}, 32'd0);
        check("rst_empty", {31'b0, ras_empty}, 32'd1);

        // sequential fetch
        idle();
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check("seq_pc", pc, 32'h10074 + 32'(4 * i));
            check("seq_valid", {31'b0, pc_valid}, 32'd1);
        end

        // backward branch taken / not taken from the same PC
        idle(); ctrl_sel = 2'b10; offset = 32'hFFFF_FFF0; branch_tkn = 1'b1; cycle();
        check("br_taken", pc, 32'h10070);
        do_trap(32'h10080);
        idle(); ctrl_sel = 2'b10; offset = 32'hFFFF_FFF0; branch_tkn = 1'b0; cycle();
        check("br_not_taken", pc, 32'h10084);

        // misaligned jump, then trap redirect
        idle(); ctrl_sel = 2'b01; tgt_addr = 32'h20002; cycle();
        check("mis_hold", pc, 32'h10084);
        check("mis_pulse", {31'b0, misalign}, 32'd1);
        do_trap(32'h100);
        check("trap_pc", pc, 32'h100);
        check("trap_mis", {31'b0, misalign}, 32'd0);

        // call / return
        do_trap(32'h1000);
        idle(); ctrl_sel = 2'b01; push = 1'b1; tgt_addr = 32'h2000; cycle();
        check("call_pc", pc, 32'h2000);
        idle(); ctrl_sel = 2'b11; tgt_addr = 32'hDEAD0; cycle();
        check("ret_pc", pc, 32'h1004);
        check("ret_empty", {31'b0, ras_empty}, 32'd1);

        // overflow: 5 calls, 4 predicted returns, 5th falls back to tgt_addr
        for (int k = 0; k < 5; k++) begin
            idle(); ctrl_sel = 2'b01; push = 1'b1; tgt_addr = 32'h3000 + 32'(k * 'h100); cycle();
        end
        check("ovf_full", {31'b0, ras_full}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            idle(); ctrl_sel = 2'b11; tgt_addr = 32'hDEAD0; cycle();
            check("ovf_ret", pc, 32'h3304 - 32'(k * 'h100));
        end
        check("ovf_empty", {31'b0, ras_empty}, 32'd1);
        idle(); ctrl_sel = 2'b11; tgt_addr = 32'h5551; cycle();
        check("ret_fallback", pc, 32'h5550);

        // stall holds PC and RAS, then mid-sequence reset
        idle(); ctrl_sel = 2'b01; push = 1'b1; tgt_addr = 32'h6000; cycle();
        for (int k = 0; k < 2; k++) begin
            idle(); stall = 1'b1; ctrl_sel = 2'b01; push = 1'b1; tgt_addr = 32'h7000; cycle();
            check("stall_pc", pc, 32'h6000);
        end
        idle(); rst = 1'b1; ctrl_sel = 2'b01; push = 1'b1; tgt_addr = 32'h7000; cycle();
        check("midrst_pc", pc, 32'h10074);
        check("midrst_empty", {31'b0, ras_empty}, 32'd1);
        idle(); ctrl_sel = 2'b11; tgt_addr = 32'h8000; cycle();
        check("midrst_ret", pc, 32'h8000);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst        = ($urandom_range(0, 99) == 0);
            trap       = ($urandom_range(0, 15) == 0);
            stall      = ($urandom_range(0, 7) == 0);
            push       = ($urandom_range(0, 2) == 0);
            ctrl_sel   = 2'($urandom_range(0, 3));
            branch_tkn = 1'($urandom_range(0, 1));
            offset     = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 255)) - 32'd128
                                                     : (32'($urandom_range(0, 63)) << 2) - 32'd128;
            tgt_addr   = ($urandom_range(0, 5) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_FFFC);
            trap_vec   = 32'($urandom) & 32'hFFFF_FFFC;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the single-issue core; replaces the fixed 32-bit PC register.
- Sits between the decoder/ALU (control-transfer requests) and instruction fetch (pc_o).
- New over the previous PC block: configurable width, reset vector and alignment; stall and trap redirect; misaligned-target detection; a return-address stack (RAS) predicting targets for returns.

Parameters:
- ADDR_WIDTH, 32, width of all addresses and offsets.
- RESET_ADDR, 'h10074, PC value loaded while rst is high.
- IALIGN, 4, required target alignment in bytes; legal values are 2 (compressed ISA) or 4.
- RAS_DEPTH, 4, number of RAS entries; must be a power of two and at least 2.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- ctrl_sel_i  in  2  from decoder: 00 NONE, 01 JUMP, 10 BRANCH, 11 RETURN.
- offset_i  in  ADDR_WIDTH  branch offset, signed, added to pc_o.
- branch_tkn_i  in  1  ALU comparison result; used only for BRANCH.
- tgt_addr_i  in  ADDR_WIDTH  ALU jump target; also the RETURN target when the RAS is empty.
- push_i  in  1  call indication (JAL/JALR with rd=ra); pushes pc_o+4 onto the RAS.
- stall_i  in  1  hold the PC and the RAS this cycle.
- trap_i  in  1  redirect to trap_vec_i.
- trap_vec_i  in  ADDR_WIDTH  trap target.
- pc_o  out  ADDR_WIDTH  current PC, registered.
- pc_plus4_o  out  ADDR_WIDTH  pc_o+4, combinational; link address.
- pc_valid_o  out  1  pc_o is fetchable.
- misalign_o  out  1  registered pulse: the last requested target was misaligned.
- ras_empty_o  out  1  RAS occupancy = 0.
- ras_full_o  out  1  RAS occupancy = RAS_DEPTH.

Behaviour:
- Reset, while rst=1:
  - pc_o=RESET_ADDR, pc_valid_o=0, misalign_o=0.
  - RAS occupancy=0 (ras_empty_o=1, ras_full_o=0); RAS pointer=0.
  - All other inputs ignored. Reset mid-operation discards RAS contents immediately.
- pc_valid_o becomes 1 on the first edge with rst=0 and stays 1 until the next reset.
- Per-edge priority (rst=0): trap_i > stall_i > ctrl_sel_i.
- trap_i=1:
  - pc_o<=trap_vec_i, with no alignment check.
  - RAS unchanged; push_i and stall_i ignored; misalign_o<=0.
- stall_i=1 (no trap): pc_o and RAS hold; misalign_o<=0.
- Next-target computation (next):
  - NONE: pc_o+4.
  - JUMP: tgt_addr_i with bit 0 cleared.
  - BRANCH: branch_tkn_i ? pc_o+offset_i : pc_o+4.
  - RETURN: RAS top if not empty, else tgt_addr_i with bit 0 cleared.
- Arithmetic is modulo 2^ADDR_WIDTH; wrap-around is silent.
- Alignment check on next:
  - IALIGN=4: misaligned if bit 1 is set.
  - IALIGN=2: bit 0 is already cleared for jumps, so misaligned only if a branch target has bit 0 set.
- Misaligned target: pc_o holds, misalign_o<=1 for exactly one cycle, no RAS push or pop. The trap unit is expected to assert trap_i afterwards.
- Aligned target: pc_o<=next; misalign_o<=0.
- RAS, circular buffer:
  - Push writes pc_plus4_o at ptr+1 and advances ptr; occupancy saturates at RAS_DEPTH.
  - Push while full overwrites the oldest entry.
  - Pop (RETURN with RAS not empty) decrements ptr and occupancy.
  - Pop on empty: no state change; falls back to tgt_addr_i.
  - Simultaneous pop and push (RETURN with push_i): top entry is replaced by pc_plus4_o; ptr and occupancy unchanged.
  - push_i with ctrl_sel_i other than JUMP or RETURN is ignored.
- Latency: one cycle from a request to the new pc_o. No bypass; fetch sees the new PC the cycle after the decode request.

Test Plan:
- Reset then NONE for 3 cycles: pc_o = 'h10074 → 'h10078 → 'h1007C → 'h10080; pc_valid_o=0 during rst, 1 from the first post-reset edge.
- BRANCH from 'h10080, offset_i='hFFFFFFF0: branch_tkn_i=1 → pc_o='h10070; branch_tkn_i=0 → pc_o='h10084.
- JUMP tgt='h20002 with IALIGN=4 → pc_o holds, misalign_o=1 for 1 cycle; next cycle trap_i=1, trap_vec_i='h100 → pc_o='h100, misalign_o=0.
- From pc_o='h1000, JUMP+push_i to 'h2000, then RETURN with tgt_addr_i='hDEAD0 → pc_o='h2000 then 'h1004; ras_empty_o=1 after the pop.
- RAS_DEPTH=4, 5 pushes of links L1..L5 → ras_full_o=1; 4 RETURNs yield L5, L4, L3, L2; 5th RETURN uses tgt_addr_i.
- stall_i=1 with JUMP+push_i for 2 cycles → pc_o and RAS unchanged; assert rst for 1 cycle mid-sequence → pc_o='h10074, ras_empty_o=1 on the next edge.
